// File: rtl/jtcop_mbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_mbox_pkg
// Description : Shared types and helpers for the jtcop_mbox mailbox:
//               - IRQ state encoding.
//               - Doorbell address calculation.
//               - Lowest-set-bit priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package jtcop_mbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } irq_state_t;

    // Doorbells are packed downwards from the top word of the shared RAM.
    // Channel k therefore sits at 2**aw-1-k.
    function automatic int unsigned doorbell_addr(input int unsigned aw,
                                                  input int unsigned k);
        return (32'd1 << aw) - 32'd1 - k;
    endfunction

    // Returns the index of the lowest set bit, or 0 when no bit is set.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtcop_mbox_if.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_mbox_if
// Description : Bus bundle between the two CPUs and the mailbox.
//               master : CPU side. Drives the strobes, addresses and write
//                        data; receives the read data and sub_waitn.
//               slave  : mailbox side.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtcop_mbox_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          main_cs;
    logic          main_we;
    logic [AW-1:0] main_addr;
    logic [DW-1:0] main_dout;
    logic [DW-1:0] main_din;
    logic          sub_cs;
    logic          sub_we;
    logic [AW-1:0] sub_addr;
    logic [DW-1:0] sub_dout;
    logic [DW-1:0] sub_din;
    logic          sub_waitn;

    modport master (
        output main_cs, main_we, main_addr, main_dout,
        output sub_cs,  sub_we,  sub_addr,  sub_dout,
        input  main_din, sub_din, sub_waitn
    );

    modport slave (
        input  main_cs, main_we, main_addr, main_dout,
        input  sub_cs,  sub_we,  sub_addr,  sub_dout,
        output main_din, sub_din, sub_waitn
    );
endinterface
`default_nettype wire

// File: rtl/jtcop_mbox_irq.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_mbox_irq
// Description : Doorbell pending flags and sub-CPU interrupt generation.
//               The interrupt has a minimum low width and a priority vector.
//               Optional per-channel timeout is enabled by MBOX_TIMEOUT_EN.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_set, i_clr  - per-channel doorbell set / clear requests
//               o_pend        - pending flags
//               o_vec         - lowest pending channel (registered)
//               o_irqn        - active-low interrupt
//               o_tmo         - timeout pulse (MBOX_TIMEOUT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module jtcop_mbox_irq
    import jtcop_mbox_pkg::*;
#(
    parameter int CH      = 1,
    parameter int IRQ_MIN = 4
`ifdef MBOX_TIMEOUT_EN
    ,
    parameter int TMO     = 1024
`endif
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [CH-1:0] i_set,
    input  wire logic [CH-1:0] i_clr,
    output logic      [CH-1:0] o_pend,
    output logic      [2:0]    o_vec,
    output logic               o_irqn
`ifdef MBOX_TIMEOUT_EN
    ,
    output logic               o_tmo
`endif
);

    irq_state_t      r_state, w_state_nxt;
    logic [7:0]      r_cnt,   w_cnt_nxt;
    logic [CH-1:0]   r_pend;
    logic [2:0]      r_vec;
    logic [CH-1:0]   w_hit;
    logic            w_irqn;

`ifdef MBOX_TIMEOUT_EN
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    logic r_tmo;

    for (genvar k = 0; k < CH; k++) begin : g_tmo
        logic [TW-1:0] r_tcnt;
        // A fresh set restarts the count even if the flag was already high.
        always_ff @(posedge clk) begin
            if (rst)               r_tcnt <= '0;
            else if (i_set[k])     r_tcnt <= '0;
            else if (r_pend[k])    r_tcnt <= r_tcnt + 1'b1;
        end
        assign w_hit[k] = r_pend[k] && (r_tcnt == TW'(TMO - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) r_tmo <= 1'b0;
        else     r_tmo <= |(w_hit & ~i_set);
    end
    assign o_tmo = r_tmo;
`else
    assign w_hit = '0;
`endif

    // A set in the same cycle as a clear or timeout takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_vec  <= 3'd0;
        end else begin
            r_pend <= (r_pend & ~i_clr & ~w_hit) | i_set;
            r_vec  <= prio_enc(8'(r_pend));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // In HOLD, the line follows pend directly. As a result, a doorbell
    // already serviced during ASSERT releases the IRQ exactly after IRQ_MIN
    // cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_irqn      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = ST_ASSERT;
                    w_cnt_nxt   = 8'(IRQ_MIN - 1);
                end
            end
            ST_ASSERT: begin
                w_irqn = 1'b0;
                if (r_cnt == 8'd0) w_state_nxt = ST_HOLD;
                else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            ST_HOLD: begin
                w_irqn = ~(|r_pend);
                if (~(|r_pend)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_pend = r_pend;
    assign o_vec  = r_vec;
    assign o_irqn = w_irqn;

endmodule
`default_nettype wire

// File: rtl/jtcop_mbox.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_mbox
// Description : Shared-RAM mailbox between the main 68000 and a sub-CPU.
//               Provides a read-first true-dual-port RAM and write-collision
//               arbitration, where main wins and the sub is held off with
//               sub_waitn. It also has CH doorbell channels at the top of
//               the RAM, which drive a prioritised interrupt.
//               Optional feature macro: MBOX_TIMEOUT_EN (adds sub_tmo).
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus       - main/sub CPU buses (jtcop_mbox_if.slave)
//               sub_irqn  - active-low interrupt to the sub-CPU
//               sub_vec   - lowest pending channel
//               pend      - per-channel pending flags
//               sub_tmo   - doorbell timeout pulse (MBOX_TIMEOUT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module jtcop_mbox
    import jtcop_mbox_pkg::*;
#(
    parameter int AW      = 11,
    parameter int DW      = 8,
    parameter int CH      = 1,
    parameter int IRQ_MIN = 4,
    parameter int TMO     = 1024
) (
    input  wire logic          clk,
    input  wire logic          rst,
    jtcop_mbox_if.slave        bus,
    output logic               sub_irqn,
    output logic [2:0]         sub_vec,
    output logic [CH-1:0]      pend
`ifdef MBOX_TIMEOUT_EN
    ,
    output logic               sub_tmo
`endif
);

    if (CH < 1 || CH > 8 || IRQ_MIN < 1 || IRQ_MIN > 255 || TMO < 1) begin : g_bad_param
        $error("jtcop_mbox: parameter out of range");
    end

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_main_din;
    logic [DW-1:0] r_sub_din;

    logic w_main_wr, w_sub_wr, w_collide, w_sub_commit;
    logic w_main_rd, w_sub_rd;

    assign w_main_wr    = bus.main_cs & bus.main_we;
    assign w_sub_wr     = bus.sub_cs  & bus.sub_we;
    assign w_main_rd    = bus.main_cs & ~bus.main_we;
    assign w_sub_rd     = bus.sub_cs  & ~bus.sub_we;
    assign w_collide    = w_main_wr & w_sub_wr & (bus.main_addr == bus.sub_addr);
    assign w_sub_commit = w_sub_wr & ~w_collide;

    // Committed writes always target distinct addresses. Both ports can
    // therefore update the array in one process. Writes in the reset cycle
    // are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_main_wr)    r_mem[bus.main_addr] <= bus.main_dout;
            if (w_sub_commit) r_mem[bus.sub_addr]  <= bus.sub_dout;
        end
    end

    // Non-blocking reads in the same edge as the writes make both ports
    // read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_din <= '0;
            r_sub_din  <= '0;
        end else begin
            if (w_main_rd) r_main_din <= r_mem[bus.main_addr];
            if (w_sub_rd)  r_sub_din  <= r_mem[bus.sub_addr];
        end
    end

    assign bus.main_din  = r_main_din;
    assign bus.sub_din   = r_sub_din;
    assign bus.sub_waitn = ~w_collide;

    logic [CH-1:0] w_db_set, w_db_clr;

    // Only main writes raise a doorbell and only sub reads clear it.
    // Sub writes to these addresses just store data.
    for (genvar k = 0; k < CH; k++) begin : g_db
        assign w_db_set[k] = w_main_wr && (bus.main_addr == AW'(doorbell_addr(AW, k)));
        assign w_db_clr[k] = w_sub_rd  && (bus.sub_addr  == AW'(doorbell_addr(AW, k)));
    end

    jtcop_mbox_irq #(
        .CH      (CH),
        .IRQ_MIN (IRQ_MIN)
`ifdef MBOX_TIMEOUT_EN
        ,
        .TMO     (TMO)
`endif
    ) u_irq (
        .clk    (clk),
        .rst    (rst),
        .i_set  (w_db_set),
        .i_clr  (w_db_clr),
        .o_pend (pend),
        .o_vec  (sub_vec),
        .o_irqn (sub_irqn)
`ifdef MBOX_TIMEOUT_EN
        ,
        .o_tmo  (sub_tmo)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_jtcop_mbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtcop_mbox
// Description : Directed self-checking bench for jtcop_mbox (AW=11, CH=2,
//               IRQ_MIN=4, TMO=16). Inputs change 1 time unit after each
//               rising edge, and outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtcop_mbox;

    logic       clk;
    logic       rst;
    logic       sub_irqn;
    logic [2:0] sub_vec;
    logic [1:0] pend;
`ifdef MBOX_TIMEOUT_EN
    logic       sub_tmo;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    jtcop_mbox_if #(.AW(11), .DW(8)) bus ();

    jtcop_mbox #(
        .AW(11), .DW(8), .CH(2), .IRQ_MIN(4), .TMO(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sub_irqn (sub_irqn),
        .sub_vec  (sub_vec),
        .pend     (pend)
`ifdef MBOX_TIMEOUT_EN
        ,
        .sub_tmo  (sub_tmo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.main_cs = 1'b0; bus.main_we = 1'b0; bus.main_addr = '0; bus.main_dout = '0;
        bus.sub_cs  = 1'b0; bus.sub_we  = 1'b0; bus.sub_addr  = '0; bus.sub_dout  = '0;
    endtask

    task automatic main_acc(input logic we, input logic [10:0] a, input logic [7:0] d);
        bus.main_cs = 1'b1; bus.main_we = we; bus.main_addr = a; bus.main_dout = d;
    endtask

    task automatic sub_acc(input logic we, input logic [10:0] a, input logic [7:0] d);
        bus.sub_cs = 1'b1; bus.sub_we = we; bus.sub_addr = a; bus.sub_dout = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        check("rst_main_din", 32'(bus.main_din),  32'h0);
        check("rst_sub_din",  32'(bus.sub_din),   32'h0);
        check("rst_waitn",    32'(bus.sub_waitn), 32'h1);
        check("rst_irqn",     32'(sub_irqn),      32'h1);
        check("rst_vec",      32'(sub_vec),       32'h0);
        check("rst_pend",     32'(pend),          32'h0);
        rst = 1'b0;

        // Single doorbell, serviced early: IRQ low exactly IRQ_MIN cycles.
        main_acc(1'b1, 11'h7FF, 8'h5A); tick(); idle();
        check("t1_pend_set",   32'(pend),     32'h1);
        check("t1_irqn_t1",    32'(sub_irqn), 32'h1);
        tick();
        check("t1_irqn_t2",    32'(sub_irqn), 32'h0);
        check("t1_vec",        32'(sub_vec),  32'h0);
        sub_acc(1'b0, 11'h7FF, 8'h00); tick(); idle();
        check("t1_sub_din",    32'(bus.sub_din), 32'h5A);
        check("t1_pend_clr",   32'(pend),     32'h0);
        check("t1_irqn_c2",    32'(sub_irqn), 32'h0);
        tick();
        check("t1_irqn_c3",    32'(sub_irqn), 32'h0);
        tick();
        check("t1_irqn_c4",    32'(sub_irqn), 32'h0);
        tick();
        check("t1_irqn_rel",   32'(sub_irqn), 32'h1);
        tick();
        check("t1_irqn_idle",  32'(sub_irqn), 32'h1);

        // Two doorbells: priority vector and gap-free HOLD.
        main_acc(1'b1, 11'h7FE, 8'hA1); tick();
        main_acc(1'b1, 11'h7FF, 8'hB2); tick(); idle();
        check("t2_pend_both",  32'(pend),     32'h3);
        repeat (4) tick();
        check("t2_vec0",       32'(sub_vec),  32'h0);
        check("t2_irqn_hold",  32'(sub_irqn), 32'h0);
        sub_acc(1'b0, 11'h7FF, 8'h00); tick(); idle();
        check("t2_pend_ch1",   32'(pend),        32'h2);
        check("t2_irqn_nogap", 32'(sub_irqn),    32'h0);
        check("t2_din_ch0",    32'(bus.sub_din), 32'hB2);
        tick();
        check("t2_vec1",       32'(sub_vec),  32'h1);
        check("t2_irqn_still", 32'(sub_irqn), 32'h0);
        sub_acc(1'b0, 11'h7FE, 8'h00); tick(); idle();
        check("t2_pend_none",  32'(pend),        32'h0);
        check("t2_irqn_rel",   32'(sub_irqn),    32'h1);
        check("t2_din_ch1",    32'(bus.sub_din), 32'hA1);
        tick();
        check("t2_vec_back",   32'(sub_vec),  32'h0);

        // Same-address write collision: main wins, sub retries.
        main_acc(1'b1, 11'h100, 8'h11); sub_acc(1'b1, 11'h100, 8'h22);
        #1;
        check("t3_waitn_coll", 32'(bus.sub_waitn), 32'h0);
        tick();
        bus.main_cs = 1'b0; bus.main_we = 1'b0;
        #1;
        check("t3_waitn_retry", 32'(bus.sub_waitn), 32'h1);
        tick(); idle();
        main_acc(1'b0, 11'h100, 8'h00); tick(); idle();
        check("t3_final_100",  32'(bus.main_din), 32'h22);

        // Different-address writes never stall.
        main_acc(1'b1, 11'h200, 8'h33); sub_acc(1'b1, 11'h201, 8'h44);
        #1;
        check("t3_waitn_diff", 32'(bus.sub_waitn), 32'h1);
        tick(); idle();
        main_acc(1'b0, 11'h201, 8'h00); sub_acc(1'b0, 11'h200, 8'h00); tick(); idle();
        check("t3_main_201",   32'(bus.main_din), 32'h44);
        check("t3_sub_200",    32'(bus.sub_din),  32'h33);

        // Sub write to a doorbell address stores data, leaves pend alone.
        sub_acc(1'b1, 11'h7FE, 8'h55); tick(); idle();
        check("t3_subdb_pend", 32'(pend), 32'h0);
        main_acc(1'b0, 11'h7FE, 8'h00); tick(); idle();
        check("t3_subdb_data", 32'(bus.main_din), 32'h55);

        // Same-cycle sub read and main write of a doorbell.
        sub_acc(1'b0, 11'h7FF, 8'h00); main_acc(1'b1, 11'h7FF, 8'hC3); tick(); idle();
        check("t4_read_old",   32'(bus.sub_din), 32'hB2);
        check("t4_set_wins",   32'(pend),        32'h1);
        sub_acc(1'b0, 11'h7FF, 8'h00); tick(); idle();
        check("t4_read_new",   32'(bus.sub_din), 32'hC3);
        check("t4_pend_clr",   32'(pend),        32'h0);
        repeat (6) tick();
        check("t4_irqn_idle",  32'(sub_irqn), 32'h1);

        // Reset during ASSERT; the write in the reset cycle is dropped.
        main_acc(1'b1, 11'h300, 8'h66); tick(); idle();
        main_acc(1'b1, 11'h7FF, 8'hD4); tick(); idle();
        tick();
        check("t5_irqn_assert", 32'(sub_irqn), 32'h0);
        rst = 1'b1;
        main_acc(1'b1, 11'h300, 8'h77); tick(); idle();
        check("t5_irqn_rst",   32'(sub_irqn), 32'h1);
        check("t5_pend_rst",   32'(pend),     32'h0);
        rst = 1'b0;
        main_acc(1'b0, 11'h300, 8'h00); tick(); idle();
        check("t5_rst_write",  32'(bus.main_din), 32'h66);
        check("t5_irqn_after", 32'(sub_irqn),     32'h1);

`ifdef MBOX_TIMEOUT_EN
        // Unread doorbell times out exactly TMO cycles after it was set.
        main_acc(1'b1, 11'h7FE, 8'hE5); tick(); idle();
        check("t6_pend_set",   32'(pend), 32'h2);
        repeat (15) tick();
        check("t6_pend_t15",   32'(pend),    32'h2);
        check("t6_tmo_t15",    32'(sub_tmo), 32'h0);
        tick();
        check("t6_pend_t16",   32'(pend),    32'h0);
        check("t6_tmo_t16",    32'(sub_tmo), 32'h1);
        tick();
        check("t6_tmo_t17",    32'(sub_tmo), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
